bus_periph_regfile: RTL
=======================

Name: bus_periph_regfile

Overview:
- Generic memory-mapped peripheral register file for the 8-bit processor bus; the parametrised successor of the per-device bus front ends (mouse and similar IO blocks).
- Provides N writable control bytes, a live read-only status window, and a multi-source interrupt controller with mask, sticky pending bits and write-1-to-clear.
- Sits between the shared BUS_DATA/BUS_ADDR/BUS_WE bus and one device core; raises a single BUS_INTERRUPT_RAISE line to the processor.

Parameters:
- BASE_ADDR, 8'hA0, bus address of offset 0.
- NUM_REGS, 16, window size in bytes; power of 2, range 4..128; BASE_ADDR+NUM_REGS <= 256.
- NUM_CTRL, 4, writable control bytes at offsets 0..NUM_CTRL-1; range 1..NUM_REGS-3.
- NUM_EVENTS, 4, interrupt sources; range 1..8.
- Derived: NUM_STAT = NUM_REGS-NUM_CTRL-2; MASK_OFS = NUM_CTRL; PEND_OFS = NUM_CTRL+1; STAT_OFS = NUM_CTRL+2.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during reads of this window.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = processor write cycle.
- BUS_INTERRUPT_RAISE  out  1  interrupt request to the processor.
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from the processor.
- CTRL_OUT  out  8*NUM_CTRL  control bytes; byte k is bits [8k+7:8k].
- STATUS_IN  in  8*NUM_STAT  device status; byte j maps to offset STAT_OFS+j.
- EVENT_IN  in  NUM_EVENTS  device event lines; a rising edge sets pending.
- IRQ_PEND_OUT  out  NUM_EVENTS  current pending vector, for debug.

Behaviour:
- Reset: control bytes, mask, pending, event history, drive enable, read-data register and BUS_INTERRUPT_RAISE all go to 0. BUS_DATA is high-Z.
- Hit: BUS_ADDR in [BASE_ADDR, BASE_ADDR+NUM_REGS). Offset = BUS_ADDR-BASE_ADDR, truncated to log2(NUM_REGS) bits.
- Read path:
  - Every cycle, the read-data register <= contents at the offset, taken before any same-edge update.
  - Drive enable <= hit & !BUS_WE.
  - BUS_DATA = drive enable ? read-data : Z.
  - Result: 1-cycle read latency. A write followed by a read of the same offset returns the new value.
- Writes (hit & BUS_WE): drive enable <= 0.
  - Offset < NUM_CTRL: byte written.
  - MASK_OFS: mask <= data[NUM_EVENTS-1:0]; upper bits ignored and read as 0.
  - PEND_OFS: write-1-to-clear on the pending bits.
  - Status offsets: write ignored.
- Status: status byte j is registered from STATUS_IN every cycle (1-cycle sample latency). No snapshotting.
- Event capture: prev <= EVENT_IN each cycle; rise = EVENT_IN & ~prev.
  - A level held high sets pending once only.
  - An event that is high out of reset does not set pending in the first cycle after reset.
- Pending update, per bit: pend <= (pend & ~clr) | rise.
  - clr = W1C data on a PEND_OFS write, OR mask on the ACK cycle.
  - Set wins over clear in the same cycle.
  - Unmasked bits still latch pending and are readable.
- BUS_INTERRUPT_RAISE <= |(pend_next & mask_next), registered: asserts 1 cycle after the qualifying edge.
  - ACK clears the masked pending bits.
  - Raise drops the cycle after ACK unless a new masked rise arrives in the ACK cycle.
  - Setting mask over an already-pending bit raises the next cycle.
- No state machine beyond edge/pending registers; all outputs registered. CTRL_OUT is direct from the registers.

Decomposition:
- Package bus_periph_pkg: BUS_DATA_W=8, derived offset functions (mask_ofs, pend_ofs, stat_ofs, num_stat), address-hit function.
- Sub-module irq_event_capture: edge detect, pending, mask, W1C, ACK and raise logic for NUM_EVENTS sources.
- Decode, read mux and tristate stay in the top.

Test Plan (defaults: mask A4, pend A5, status A6..AF):
- Reset, then read A0..AF with STATUS_IN=0: BUS_DATA returns 00 each read; BUS_DATA is Z on cycles with a non-hit address or BUS_WE=1.
- Write A2=5A, A6=FF (status), A4=F3, then read back:
  - CTRL_OUT[23:16]=5A the cycle after the write.
  - A6 reads the STATUS_IN byte 0 value, not FF.
  - A4 reads 03.
- Mask=0, pulse EVENT_IN[2]: A5 reads 04, raise stays 0. Then write A4=04: raise=1 on the next cycle. Then ACK: A5 reads 00 and raise=0 one cycle later.
- Pending=05, mask=01, write A5=01: pending=04, raise=0. Write A5=04: pending=00.
- EVENT_IN[1] rises in the same cycle as a W1C of bit 1 and an ACK (mask=02): bit 1 stays pending and raise stays 1.
- STATUS_IN byte 9 changes from 11 to 22: a read of AF one cycle later returns 22. Assert RESET mid-read: BUS_DATA is Z the next cycle and all registers are 0.

Source files
------------

// File: rtl/bus_periph_regfile_pkg.sv
// Shared constants and helpers for the memory-mapped peripheral register file.
// The register window holds the control bytes first, then the mask byte,
// then the pending byte, and then the read-only status bytes.
package bus_periph_pkg;

    localparam int BUS_DATA_W = 8;

    function automatic int mask_ofs(input int num_ctrl);
        return num_ctrl;
    endfunction

    function automatic int pend_ofs(input int num_ctrl);
        return num_ctrl + 1;
    endfunction

    function automatic int stat_ofs(input int num_ctrl);
        return num_ctrl + 2;
    endfunction

    function automatic int num_stat(input int num_regs, input int num_ctrl);
        return num_regs - num_ctrl - 2;
    endfunction

    // The upper bound is computed in 9 bits so that a window ending exactly
    // at address 256 does not wrap around.
    function automatic logic addr_hit(input logic [BUS_DATA_W-1:0] addr,
                                      input logic [BUS_DATA_W-1:0] base,
                                      input int num_regs);
        logic [BUS_DATA_W:0] limit;
        limit = {1'b0, base} + (BUS_DATA_W+1)'(num_regs);
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/bus_periph_regfile_if.sv
// Processor-side bus bundle for one peripheral register file.
// BUS_DATA is resolved here from the two possible drivers. The processor's
// write data has priority, and the line floats when neither side drives it.
interface bus_periph_regfile_if;

    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;
    logic [7:0] wdata;
    logic       wdata_en;
    logic [7:0] rdata;
    logic       rdata_en;
    wire  [7:0] BUS_DATA;

    assign BUS_DATA = wdata_en ? wdata : (rdata_en ? rdata : 8'hzz);

    modport master (
        output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, wdata, wdata_en,
        input  BUS_DATA, BUS_INTERRUPT_RAISE, rdata_en
    );

    modport slave (
        input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, BUS_DATA,
        output BUS_INTERRUPT_RAISE, rdata, rdata_en
    );

endinterface

// File: rtl/bus_periph_regfile_irq.sv
// Interrupt controller for the register file. It detects rising edges on the
// event lines, holds sticky pending bits and a mask, supports write-1-to-clear
// and acknowledge, and produces one registered raise line.
module irq_event_capture #(
    parameter int NUM_EVENTS = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic [NUM_EVENTS-1:0] wr_data,
    input  logic                  mask_wr,
    input  logic                  pend_wr,
    input  logic                  ack,
    output logic [NUM_EVENTS-1:0] mask,
    output logic [NUM_EVENTS-1:0] pend,
    output logic                  raise
);

    logic [NUM_EVENTS-1:0] prev;
    logic [NUM_EVENTS-1:0] rise;
    logic [NUM_EVENTS-1:0] clr;
    logic [NUM_EVENTS-1:0] pend_next;
    logic [NUM_EVENTS-1:0] mask_next;
    logic                  armed;

    // The armed flag suppresses rise detection for one cycle after reset.
    // This stops a line that is already high from looking like a fresh edge.
    // A new rise sets its pending bit even if the same cycle clears that bit.
    always_comb begin
        rise      = armed ? (event_in & ~prev) : '0;
        clr       = '0;
        if (pend_wr)
            clr = clr | wr_data;
        if (ack)
            clr = clr | mask;
        pend_next = (pend & ~clr) | rise;
        mask_next = mask_wr ? wr_data : mask;
    end

    // This block updates the edge history, mask and pending bits.
    // Raise is computed from the post-update values, so it follows a
    // qualifying edge or a mask write by one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev  <= '0;
            armed <= 1'b0;
            mask  <= '0;
            pend  <= '0;
            raise <= 1'b0;
        end else begin
            prev  <= event_in;
            armed <= 1'b1;
            mask  <= mask_next;
            pend  <= pend_next;
            raise <= |(pend_next & mask_next);
        end
    end

endmodule

// File: rtl/bus_periph_regfile.sv
// Memory-mapped register file that sits between the shared 8-bit bus and one
// device core. It holds the writable control bytes, the interrupt mask, the
// pending bits and a live status window. Read data appears one cycle after
// the address.
module bus_periph_regfile
    import bus_periph_pkg::*;
#(
    parameter logic [BUS_DATA_W-1:0] BASE_ADDR  = 8'hA0,
    parameter int                    NUM_REGS   = 16,
    parameter int                    NUM_CTRL   = 4,
    parameter int                    NUM_EVENTS = 4
) (
    input  logic                                               CLK,
    input  logic                                               RESET,
    bus_periph_regfile_if.slave                                bus,
    output logic [BUS_DATA_W*NUM_CTRL-1:0]                     CTRL_OUT,
    input  logic [BUS_DATA_W*num_stat(NUM_REGS, NUM_CTRL)-1:0] STATUS_IN,
    input  logic [NUM_EVENTS-1:0]                              EVENT_IN,
    output logic [NUM_EVENTS-1:0]                              IRQ_PEND_OUT
);

    localparam int OFS_W    = $clog2(NUM_REGS);
    localparam int NUM_STAT = num_stat(NUM_REGS, NUM_CTRL);
    localparam int MASK_OFS = mask_ofs(NUM_CTRL);
    localparam int PEND_OFS = pend_ofs(NUM_CTRL);
    localparam int STAT_OFS = stat_ofs(NUM_CTRL);

    logic                  hit;
    logic                  wr_hit;
    logic [OFS_W-1:0]      ofs;
    logic [BUS_DATA_W-1:0] ctrl_q [NUM_CTRL];
    logic [BUS_DATA_W-1:0] stat_q [NUM_STAT];
    logic [NUM_EVENTS-1:0] mask;
    logic [NUM_EVENTS-1:0] pend;
    logic                  mask_wr;
    logic                  pend_wr;
    logic [BUS_DATA_W-1:0] rd_next;
    logic [BUS_DATA_W-1:0] rd_q;
    logic                  drive_q;

    assign hit     = addr_hit(bus.BUS_ADDR, BASE_ADDR, NUM_REGS);
    assign wr_hit  = hit & bus.BUS_WE;
    assign ofs     = OFS_W'(bus.BUS_ADDR - BASE_ADDR);
    assign mask_wr = wr_hit && (ofs == OFS_W'(MASK_OFS));
    assign pend_wr = wr_hit && (ofs == OFS_W'(PEND_OFS));

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
        assign CTRL_OUT[BUS_DATA_W*k +: BUS_DATA_W] = ctrl_q[k];
    end

    assign IRQ_PEND_OUT = pend;
    assign bus.rdata    = rd_q;
    assign bus.rdata_en = drive_q;

    irq_event_capture #(
        .NUM_EVENTS (NUM_EVENTS)
    ) u_irq (
        .CLK      (CLK),
        .RESET    (RESET),
        .event_in (EVENT_IN),
        .wr_data  (bus.BUS_DATA[NUM_EVENTS-1:0]),
        .mask_wr  (mask_wr),
        .pend_wr  (pend_wr),
        .ack      (bus.BUS_INTERRUPT_ACK),
        .mask     (mask),
        .pend     (pend),
        .raise    (bus.BUS_INTERRUPT_RAISE)
    );

    // The read mux uses register contents from before this edge's update.
    // Mask and pending bits above NUM_EVENTS read back as zero.
    always_comb begin
        rd_next = '0;
        if (hit) begin
            for (int k = 0; k < NUM_CTRL; k++)
                if (ofs == OFS_W'(k))
                    rd_next = ctrl_q[k];
            if (ofs == OFS_W'(MASK_OFS))
                rd_next = BUS_DATA_W'(mask);
            if (ofs == OFS_W'(PEND_OFS))
                rd_next = BUS_DATA_W'(pend);
            for (int j = 0; j < NUM_STAT; j++)
                if (ofs == OFS_W'(STAT_OFS + j))
                    rd_next = stat_q[j];
        end
    end

    // Only processor writes that hit the control offsets change these bytes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < NUM_CTRL; k++)
                ctrl_q[k] <= '0;
        end else if (wr_hit) begin
            for (int k = 0; k < NUM_CTRL; k++)
                if (ofs == OFS_W'(k))
                    ctrl_q[k] <= bus.BUS_DATA;
        end
    end

    // Status bytes follow the device every cycle, so writes never land here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int j = 0; j < NUM_STAT; j++)
                stat_q[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_STAT; j++)
                stat_q[j] <= STATUS_IN[BUS_DATA_W*j +: BUS_DATA_W];
        end
    end

    // This block registers the read data and the drive enable.
    // The bus is driven only in the cycle after a read that hits this window.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_q    <= '0;
            drive_q <= 1'b0;
        end else begin
            rd_q    <= rd_next;
            drive_q <= hit & ~bus.BUS_WE;
        end
    end

endmodule
